// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one 16->32 sign/zero immediate extender, with a one-entry registered output.
// Optional `define IMM_EXT_LUI_EN adds req_lui for upper-immediate placement ({imm, 16'h0000}).
module imm_ext_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [16*NUM_REQ-1:0] req_imm,
  input  logic [NUM_REQ-1:0]    req_ext,
`ifdef IMM_EXT_LUI_EN
  input  logic [NUM_REQ-1:0]    req_lui,
`endif
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic [ID_W-1:0]       resp_id,
  input  logic                  resp_ready
);

  localparam int unsigned NR = NUM_REQ;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic             accept;
  logic             found;
  int unsigned      grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [15:0]      imm;
  logic [31:0]      ext_data;
  logic [ID_W-1:0]  next_ptr;

  assign accept = (state == EMPTY) || resp_ready;

  // Search starts at rr_ptr and wraps; req_ready is forced low while in reset.
  always_comb begin
    int unsigned idx;
    found     = 1'b0;
    grant_idx = 0;
    grant     = '0;
    idx       = 0;
    if (rst_n && accept) begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NR) idx = idx - NR;
        if (!found && req_valid[idx]) begin
          found     = 1'b1;
          grant_idx = idx;
        end
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    imm      = req_imm[16*grant_idx +: 16];
    ext_data = {{16{req_ext[grant_idx] & imm[15]}}, imm};
`ifdef IMM_EXT_LUI_EN
    if (req_lui[grant_idx]) ext_data = {imm, 16'h0000};
`endif
  end

  always_comb begin
    if (grant_idx + 1 >= NR) next_ptr = '0;
    else                     next_ptr = ID_W'(grant_idx + 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      rr_ptr    <= '0;
      resp_data <= '0;
      resp_id   <= '0;
    end else begin
      if (found) begin
        // Drain and load in the same cycle stays FULL, so there is no bubble.
        state     <= FULL;
        resp_data <= ext_data;
        resp_id   <= ID_W'(grant_idx);
        rr_ptr    <= next_ptr;
      end else if (state == FULL && resp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign resp_valid = (state == FULL);

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: reset, extension modes, round-robin, backpressure, reset mid-operation.
// Define IMM_EXT_LUI_EN to also exercise the upper-immediate path.
module tb_imm_ext_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_imm;
  logic [1:0]  req_ext;
`ifdef IMM_EXT_LUI_EN
  logic [1:0]  req_lui;
`endif
  logic [1:0]  req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready;

  int checks   = 0;
  int failures = 0;

  imm_ext_arbiter #(.NUM_REQ(2), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_imm    (req_imm),
    .req_ext    (req_ext),
`ifdef IMM_EXT_LUI_EN
    .req_lui    (req_lui),
`endif
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] id, input logic [31:0] data);
    check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_id"}, {30'b0, resp_id}, {30'b0, id});
    check({tag, "_data"}, resp_data, data);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 2'b11;
    req_imm    = '0;
    req_ext    = 2'b00;
    resp_ready = 1'b0;
`ifdef IMM_EXT_LUI_EN
    req_lui    = 2'b00;
`endif
    #12;
    check("rst_ready", {30'b0, req_ready}, 32'd0);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_data", resp_data, 32'd0);
    check("rst_id", {30'b0, resp_id}, 32'd0);

    tick();
    rst_n = 1'b1;
    req_valid = 2'b01; req_imm[15:0] = 16'h8001; req_ext = 2'b01;
    #1 check("first_ready", {30'b0, req_ready}, 32'h1);
    tick();
    check_resp("sext", 2'd0, 32'hFFFF8001);

    // Zero-extend on requester 1 while draining (rr_ptr now 1).
    resp_ready = 1'b1;
    req_valid = 2'b10; req_imm[31:16] = 16'h8001; req_ext = 2'b01;
    #1 check("zext_ready", {30'b0, req_ready}, 32'h2);
    tick();
    check_resp("zext", 2'd1, 32'h00008001);

    req_valid = 2'b01; req_imm[15:0] = 16'h7FFF; req_ext = 2'b01;
    tick();
    check_resp("pos_sext", 2'd0, 32'h00007FFF);

    // One transfer from requester 1 brings rr_ptr back to 0.
    req_valid = 2'b10; req_imm[31:16] = 16'h5555; req_ext = 2'b01;
    tick();
    check_resp("pre_rr", 2'd1, 32'h00005555);

    req_imm[15:0] = 16'hA000; req_ext = 2'b01;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i % 2 == 0) check_resp("rr", 2'd0, 32'hFFFFA000);
      else            check_resp("rr", 2'd1, 32'h00005555);
    end

    // Backpressure: FULL with id 1, both requesters pending.
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("bp_ready", {30'b0, req_ready}, 32'd0);
      tick();
      check_resp("bp_hold", 2'd1, 32'h00005555);
    end
    resp_ready = 1'b1;
    #1 check("bp_release_ready", {30'b0, req_ready}, 32'h1);
    tick();
    check_resp("bp_after", 2'd0, 32'hFFFFA000);

    // Reset mid-operation with resp_id = 1 and rr_ptr = 0.
    req_valid = 2'b10;
    tick();
    check_resp("pre_rst", 2'd1, 32'h00005555);
    req_valid = 2'b00; resp_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_data", resp_data, 32'd0);
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11; resp_ready = 1'b1;
    #1 check("post_rst_ready", {30'b0, req_ready}, 32'h1);
    tick();
    check_resp("post_rst", 2'd0, 32'hFFFFA000);

    // Drain with no new request: data and id hold, then idle must not rotate rr_ptr.
    req_valid = 2'b00;
    tick();
    check("drain_valid", {31'b0, resp_valid}, 32'd0);
    check("drain_data", resp_data, 32'hFFFFA000);
    check("drain_id", {30'b0, resp_id}, 32'd0);
    tick(); tick();
    req_valid = 2'b11;
    #1 check("idle_rr_ready", {30'b0, req_ready}, 32'h2);
    tick();
    check_resp("idle_rr", 2'd1, 32'h00005555);

`ifdef IMM_EXT_LUI_EN
    req_valid = 2'b01; req_imm[15:0] = 16'h1234; req_ext = 2'b01; req_lui = 2'b01;
    tick();
    check_resp("lui", 2'd0, 32'h12340000);
    req_valid = 2'b10; req_imm[31:16] = 16'hF000; req_ext = 2'b10; req_lui = 2'b00;
    tick();
    check_resp("nolui", 2'd1, 32'hFFFFF000);
`endif

    req_valid = 2'b00;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
